// File: rtl/segre_id_fetch_queue.sv
// Fetch-to-decode decoupling queue: DEPTH-entry circular buffer with valid/ready on both sides.
// Optional end-of-test detection is enabled by defining SEGRE_IBUF_FINISH_DETECT_EN.
module segre_id_fetch_queue #(
  parameter int                   WORD_SIZE   = 32,
  parameter int                   ADDR_SIZE   = 32,
  parameter int                   DEPTH       = 4,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR   = 32'h00000013,
  parameter logic [ADDR_SIZE-1:0] RESET_PC    = 32'hfffffffc,
  parameter int                   STALL_CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WORD_SIZE-1:0]       in_instr_i,
  input  logic [ADDR_SIZE-1:0]       in_pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WORD_SIZE-1:0]       out_instr_o,
  output logic [ADDR_SIZE-1:0]       out_pc_o,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [STALL_CNT_W-1:0]     stall_cycles_o,
  output logic                       blocked_1cycle_ago_o,
  output logic                       finish_test_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0]       FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  logic [WORD_SIZE-1:0]   instr_mem_r [DEPTH];
  logic [ADDR_SIZE-1:0]   pc_mem_r    [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic [ADDR_SIZE-1:0]   last_pc_r;
  logic [STALL_CNT_W-1:0] stall_cnt_r;
  logic                   blocked_r;
  logic                   finish_block_s;
  logic                   out_valid_s;
  logic                   in_ready_s;
  logic                   push_s;
  logic                   pop_s;
  logic [WORD_SIZE-1:0]   out_instr_s;
  logic [ADDR_SIZE-1:0]   out_pc_s;

  assign out_valid_s = (count_r != {CNT_W{1'b0}});
  assign in_ready_s  = (count_r != FULL_CNT) && !finish_block_s;
  assign push_s      = in_valid_i && in_ready_s;
  assign pop_s       = out_valid_s && out_ready_i;

  // Head selection: stored entry when occupied, otherwise a NOP at the last consumed PC.
  always_comb begin
    out_instr_s = NOP_INSTR;
    out_pc_s    = last_pc_r;
    if (out_valid_s) begin
      out_instr_s = instr_mem_r[rd_ptr_r];
      out_pc_s    = pc_mem_r[rd_ptr_r];
    end else begin
      out_instr_s = NOP_INSTR;
      out_pc_s    = last_pc_r;
    end
  end

  // Entry storage; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (push_s && !flush_i && !rst_i) begin
      instr_mem_r[wr_ptr_r] <= in_instr_i;
      pc_mem_r[wr_ptr_r]    <= in_pc_i;
    end
  end

  // Pointers, occupancy, last consumed PC and stall observability.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      last_pc_r   <= RESET_PC;
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
      blocked_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
        last_pc_r <= out_pc_s;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      blocked_r <= out_valid_s && !out_ready_i;
      if (pop_s || !out_valid_s) begin
        stall_cnt_r <= {STALL_CNT_W{1'b0}};
      end else if (stall_cnt_r != STALL_MAX) begin
        stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
      end
    end
  end

`ifdef SEGRE_IBUF_FINISH_DETECT_EN
  localparam logic [WORD_SIZE-1:0] FINISH_INSTR = WORD_SIZE'(32'hfff01073);
  logic finish_block_r;
  logic finish_s;

  assign finish_s       = out_valid_s && (out_instr_s == FINISH_INSTR);
  assign finish_block_s = finish_block_r;

  // Once the end-of-test instruction is consumed, fetch is held off until reset or flush.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      finish_block_r <= 1'b0;
    end else if (pop_s && finish_s) begin
      finish_block_r <= 1'b1;
    end
  end

  assign finish_test_o = finish_s;
`else
  assign finish_block_s = 1'b0;
  assign finish_test_o  = 1'b0;
`endif

  assign in_ready_o           = in_ready_s;
  assign out_valid_o          = out_valid_s;
  assign out_instr_o          = out_instr_s;
  assign out_pc_o             = out_pc_s;
  assign count_o              = count_r;
  assign stall_cycles_o       = stall_cnt_r;
  assign blocked_1cycle_ago_o = blocked_r;

endmodule

// File: tb/tb_segre_id_fetch_queue.sv
// Self-checking bench for segre_id_fetch_queue: directed table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_segre_id_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] RPC  = 32'hfffffffc;
  localparam logic [31:0] FIN  = 32'hfff01073;
`ifdef SEGRE_IBUF_FINISH_DETECT_EN
  localparam bit FIN_EN = 1'b1;
`else
  localparam bit FIN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic [15:0] stall_cycles;
  logic        blocked;
  logic        finish_test;

  segre_id_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr), .in_pc_i(in_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr), .out_pc_o(out_pc),
    .flush_i(flush), .count_o(count), .stall_cycles_o(stall_cycles),
    .blocked_1cycle_ago_o(blocked), .finish_test_o(finish_test)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: a plain queue of {instr, pc} plus a few scalars.
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_last_pc = RPC;
  int          m_stall = 0;
  bit          m_blocked = 1'b0;
  bit          m_fblock = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'ha5000000;
  endfunction

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && !m_fblock;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit   v;
    bit   push;
    bit   pop;
    ent_t e;
    v    = (mq.size() != 0);
    push = in_valid && m_ready();
    pop  = v && out_ready;
    if (rst || flush) begin
      mq.delete();
      m_last_pc = RPC; m_stall = 0; m_blocked = 1'b0; m_fblock = 1'b0;
    end else begin
      m_blocked = v && !out_ready;
      if (pop || !v) m_stall = 0;
      else if (m_stall < 65535) m_stall++;
      if (pop) begin
        e = mq.pop_front();
        m_last_pc = e.pc;
        if (FIN_EN && e.instr == FIN) m_fblock = 1'b1;
      end
      if (push) begin
        e.instr = in_instr; e.pc = in_pc;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_model();
    bit v;
    v = (mq.size() != 0);
    chk("out_valid", {31'b0, out_valid}, {31'b0, v});
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready()});
    chk("count", {29'b0, count}, mq.size());
    chk("out_pc", out_pc, v ? mq[0].pc : m_last_pc);
    chk("out_instr", out_instr, v ? mq[0].instr : NOP);
    chk("stall", {16'b0, stall_cycles}, m_stall);
    chk("blocked", {31'b0, blocked}, {31'b0, m_blocked});
    chk("finish", {31'b0, finish_test}, {31'b0, FIN_EN && v && mq[0].instr == FIN});
  endtask

  task automatic drive(input bit r, input bit f, input bit iv, input logic [31:0] pc, input bit ordy);
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = instr_of(pc); out_ready = ordy;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit r; bit f; bit iv; logic [31:0] pc; bit ordy;
    bit e_valid; bit e_ready; int e_count; logic [31:0] e_pc; int e_stall;
  } vec_t;
  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 0, 0, 32'h00, 0,  0, 1, 0, RPC,     0};
    tbl[1]  = '{0, 0, 0, 32'h00, 0,  0, 1, 0, RPC,     0};
    tbl[2]  = '{0, 0, 1, 32'h00, 0,  1, 1, 1, 32'h00,  0};
    tbl[3]  = '{0, 0, 1, 32'h04, 0,  1, 1, 2, 32'h00,  1};
    tbl[4]  = '{0, 0, 1, 32'h08, 0,  1, 1, 3, 32'h00,  2};
    tbl[5]  = '{0, 0, 1, 32'h0c, 0,  1, 0, 4, 32'h00,  3};
    tbl[6]  = '{0, 0, 1, 32'h10, 0,  1, 0, 4, 32'h00,  4};
    tbl[7]  = '{0, 0, 0, 32'h00, 1,  1, 1, 3, 32'h04,  0};
    tbl[8]  = '{0, 0, 0, 32'h00, 1,  1, 1, 2, 32'h08,  0};
    tbl[9]  = '{0, 0, 0, 32'h00, 1,  1, 1, 1, 32'h0c,  0};
    tbl[10] = '{0, 0, 0, 32'h00, 1,  0, 1, 0, 32'h0c,  0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].pc, tbl[i].ordy);
      cycle();
      chk("tbl_valid", {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
      chk("tbl_ready", {31'b0, in_ready}, {31'b0, tbl[i].e_ready});
      chk("tbl_count", {29'b0, count}, tbl[i].e_count);
      chk("tbl_pc", out_pc, tbl[i].e_pc);
      chk("tbl_instr", out_instr, tbl[i].e_valid ? instr_of(tbl[i].e_pc) : NOP);
      chk("tbl_stall", {16'b0, stall_cycles}, tbl[i].e_stall);
    end

    // Streaming: prime two entries then push and pop every cycle across several wraps.
    drive(0, 0, 1, 32'h100, 0); cycle();
    drive(0, 0, 1, 32'h104, 0); cycle();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(0, 0, 1, 32'h108 + 32'(4 * i), 1); cycle();
      chk("stream_count", {29'b0, count}, 2);
      chk("stream_pc", out_pc, 32'h104 + 32'(4 * i));
    end
    drive(0, 0, 0, 32'h0, 1); cycle(); cycle();

    // Flush with a simultaneous push drops everything, including the new entry.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'h20 + 32'(4 * i), 0); cycle();
    end
    chk("pre_flush_count", {29'b0, count}, 3);
    drive(0, 1, 1, 32'h40, 0); cycle();
    chk("flush_count", {29'b0, count}, 0);
    chk("flush_pc", out_pc, RPC);
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    drive(0, 0, 1, 32'h80, 0); cycle();
    chk("after_flush_pc", out_pc, 32'h80);
    chk("after_flush_valid", {31'b0, out_valid}, 32'h1);

    // Hold the head two cycles then release.
    drive(0, 0, 0, 32'h0, 0); cycle();
    chk("hold1_blocked", {31'b0, blocked}, 32'h1);
    cycle();
    chk("hold2_blocked", {31'b0, blocked}, 32'h1);
    drive(0, 0, 0, 32'h0, 1); cycle();
    chk("release_blocked", {31'b0, blocked}, 32'h0);
    chk("release_stall", {16'b0, stall_cycles}, 0);

    // Stall counter saturation.
    drive(0, 0, 1, 32'h200, 0); cycle();
    drive(0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 65534; i++) cycle();
    chk("stall_fffe", {16'b0, stall_cycles}, 32'hfffe);
    cycle();
    chk("stall_ffff", {16'b0, stall_cycles}, 32'hffff);
    cycle(); cycle();
    chk("stall_sat", {16'b0, stall_cycles}, 32'hffff);
    drive(0, 0, 0, 32'h0, 1); cycle();
    chk("stall_clear", {16'b0, stall_cycles}, 0);

    // End-of-test instruction.
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h300; in_instr = FIN;
    cycle();
    in_valid = 1'b0;
    chk("finish_head", {31'b0, finish_test}, {31'b0, FIN_EN});
    out_ready = 1'b1; cycle();
    chk("finish_ready", {31'b0, in_ready}, {31'b0, !FIN_EN});
    cycle();
    chk("finish_ready_hold", {31'b0, in_ready}, {31'b0, !FIN_EN});
    drive(0, 1, 0, 32'h0, 0); cycle();
    chk("finish_flush_ready", {31'b0, in_ready}, 32'h1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
